idt_equiv_monitor: RTL and testbench

- Synthesizable successor to the identity fuzz bench: one block drives a shared stimulus vector into a reference DUT instance and a synthesized-netlist DUT instance, then compares their outputs every cycle.
- Generalised over stimulus width, output width, vector count and DUT pipeline latency.
- Adds pass/fail verdict, mismatch counting, first-failure capture and optional output-signature compaction.
- Sits in the generated top-level wrapper next to the two `top` instances.

---
 rtl/idt_pkg.sv | 11 +
 rtl/idt_misr.sv | 26 ++
 rtl/idt_equiv_monitor.sv | 118 +++++++++++
 tb/tb_idt_equiv_monitor.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/idt_pkg.sv
// idt_pkg: shared FSM state encoding, LFSR tap offsets and MISR polynomial for the equivalence monitor.
package idt_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  // taps are offsets below IN_W: feedback = cur[IN_W-1]^cur[IN_W-2]^cur[IN_W-4]^cur[IN_W-5]
  localparam int TAP_A = 1;
  localparam int TAP_B = 2;
  localparam int TAP_C = 4;
  localparam int TAP_D = 5;
  // feedback bits 31, 21, 1 and 0
  localparam logic [31:0] MISR_POLY = 32'h8020_0003;
endpackage

// File: rtl/idt_misr.sv
// idt_misr: folds an OUT_W-bit response into 32 bits and compacts it into a 32-bit MISR signature.
module idt_misr
  import idt_pkg::*;
#(
  parameter int OUT_W = 319
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] y,
  output logic [31:0]      sig
);
  localparam int NS = (OUT_W + 31) / 32;
  logic [NS*32-1:0] ypad;
  logic [31:0] fold;
  assign ypad = (NS*32)'(y);
  always_comb begin
    fold = '0;
    for (int i = 0; i < NS; i++) fold = fold ^ ypad[i*32 +: 32];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) sig <= '0;
    else if (clr) sig <= '0;
    else if (en) sig <= {sig[30:0], ^(sig & MISR_POLY)} ^ fold;
endmodule

// File: rtl/idt_equiv_monitor.sv
// idt_equiv_monitor: drives shared stimulus to a reference and a synthesized DUT and scores their outputs.
// Define IDT_MISR_EN to add 32-bit output signatures; otherwise sig_ref/sig_dut are tied to 0.
module idt_equiv_monitor
  import idt_pkg::*;
#(
  parameter int IN_W    = 256,
  parameter int OUT_W   = 319,
  parameter int NUM_VEC = 21,
  parameter int LAT     = 0,
  parameter int SEED    = 1,
  parameter int CNT_W   = $clog2(NUM_VEC + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IN_W-1:0]  stim,
  output logic             stim_valid,
  input  logic [OUT_W-1:0] y_ref,
  input  logic [OUT_W-1:0] y_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_valid,
  output logic [31:0]      sig_ref,
  output logic [31:0]      sig_dut
);
  localparam logic [IN_W-1:0] SEED_V = (SEED == 0) ? IN_W'(1) : IN_W'(SEED);
  state_t state, nxt;
  logic [CNT_W-1:0] k, score_i;
  logic [3:0] dcnt;
  logic [IN_W-1:0] lfsr, lfsr_nxt;
  logic go, last, score_v, mis;
  assign go = start && (state == IDLE || state == DONE);
  assign last = k == CNT_W'(NUM_VEC - 1);
  assign mis = y_ref != y_dut;
  assign lfsr_nxt = {lfsr[IN_W-2:0],
                     lfsr[IN_W-TAP_A] ^ lfsr[IN_W-TAP_B] ^ lfsr[IN_W-TAP_C] ^ lfsr[IN_W-TAP_D]};
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (go) nxt = RUN;
    else if (state == RUN && last) nxt = (LAT == 0) ? DONE : DRAIN;
    else if (state == DRAIN && dcnt == 4'(LAT - 1)) nxt = DONE;
  end
  always_comb begin
    stim_valid = state == RUN;
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
    pass = done && mismatch_cnt == '0;
  end
  // stim is loaded one cycle ahead so vector k is on the bus in RUN cycle k and holds through DRAIN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      k <= '0;
      dcnt <= '0;
      stim <= '0;
      lfsr <= SEED_V;
      mismatch_cnt <= '0;
      first_fail_idx <= '0;
      first_fail_valid <= 1'b0;
    end else if (go) begin
      k <= '0;
      dcnt <= '0;
      stim <= '0;
      lfsr <= SEED_V;
      mismatch_cnt <= '0;
      first_fail_idx <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      if (state == RUN && !last) begin
        k <= k + 1'b1;
        stim <= lfsr;
        lfsr <= lfsr_nxt;
      end
      if (state == DRAIN) dcnt <= dcnt + 4'd1;
      if (score_v && mis) begin
        if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
        if (!first_fail_valid) begin
          first_fail_idx <= score_i;
          first_fail_valid <= 1'b1;
        end
      end
    end
  generate
    if (LAT > 0) begin : g_pipe
      logic [LAT-1:0] vp;
      logic [LAT-1:0][CNT_W-1:0] ip;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          vp <= '0;
          ip <= '0;
        end else begin
          vp[0] <= stim_valid;
          ip[0] <= k;
          for (int i = 1; i < LAT; i++) begin
            vp[i] <= vp[i-1];
            ip[i] <= ip[i-1];
          end
        end
      assign score_v = vp[LAT-1];
      assign score_i = ip[LAT-1];
    end else begin : g_nopipe
      assign score_v = stim_valid;
      assign score_i = k;
    end
  endgenerate
`ifdef IDT_MISR_EN
  idt_misr #(.OUT_W(OUT_W)) u_misr_ref (.clk(clk), .rst(rst), .clr(go), .en(score_v), .y(y_ref), .sig(sig_ref));
  idt_misr #(.OUT_W(OUT_W)) u_misr_dut (.clk(clk), .rst(rst), .clr(go), .en(score_v), .y(y_dut), .sig(sig_dut));
`else
  assign sig_ref = '0;
  assign sig_dut = '0;
`endif
endmodule

// File: tb/tb_idt_equiv_monitor.sv
// tb_idt_equiv_monitor: directed checks of run timing, stimulus, scoring, abort and signatures on four monitor configurations.
module tb_idt_equiv_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic flip = 1'b0;
  int passed = 0;
  int total = 0;
  int fails = 0;
  always #5 clk = ~clk;

  logic [255:0] stim0, stim1, stim3, s1_d;
  logic [7:0] stim2;
  logic sv0, sv1, sv2, sv3, v1_d;
  logic busy0, busy1, busy2, busy3, done0, done1, done2, done3, pass0, pass1, pass2, pass3;
  logic [4:0] cnt0, cnt1, cnt3, ffi0, ffi1, ffi3;
  logic [1:0] cnt2, ffi2;
  logic ffv0, ffv1, ffv2, ffv3;
  logic [31:0] sr0, sd0, sr1, sd1, sr2, sd2, sr3, sd3;
  logic [318:0] yr0, yd0, yr1, yd1, yr3, yd3;
  logic [7:0] yr2, yd2;

  assign yr0 = {stim0, stim0[62:0]};
  assign yd0 = yr0;
  always @(posedge clk) begin
    yr1 <= {stim1, stim1[62:0]};
    v1_d <= sv1;
    s1_d <= stim1;
  end
  // vector 5 with SEED=1 is 2^4; corrupt only the response to it
  assign yd1 = yr1 ^ {318'd0, v1_d && s1_d == 256'd16};
  assign yr2 = stim2;
  assign yd2 = ~stim2;
  assign yr3 = 319'd1;
  assign yd3 = yr3 ^ {flip && sv3 && stim3 == '0, 318'd0};

  idt_equiv_monitor u0 (.clk(clk), .rst(rst), .start(start), .stim(stim0), .stim_valid(sv0), .y_ref(yr0), .y_dut(yd0),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(cnt0), .first_fail_idx(ffi0), .first_fail_valid(ffv0),
    .sig_ref(sr0), .sig_dut(sd0));
  idt_equiv_monitor #(.LAT(1)) u1 (.clk(clk), .rst(rst), .start(start), .stim(stim1), .stim_valid(sv1), .y_ref(yr1),
    .y_dut(yd1), .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(cnt1), .first_fail_idx(ffi1),
    .first_fail_valid(ffv1), .sig_ref(sr1), .sig_dut(sd1));
  idt_equiv_monitor #(.IN_W(8), .OUT_W(8), .NUM_VEC(3), .SEED(240)) u2 (.clk(clk), .rst(rst), .start(start),
    .stim(stim2), .stim_valid(sv2), .y_ref(yr2), .y_dut(yd2), .busy(busy2), .done(done2), .pass(pass2),
    .mismatch_cnt(cnt2), .first_fail_idx(ffi2), .first_fail_valid(ffv2), .sig_ref(sr2), .sig_dut(sd2));
  idt_equiv_monitor u3 (.clk(clk), .rst(rst), .start(start), .stim(stim3), .stim_valid(sv3), .y_ref(yr3), .y_dut(yd3),
    .busy(busy3), .done(done3), .pass(pass3), .mismatch_cnt(cnt3), .first_fail_idx(ffi3), .first_fail_valid(ffv3),
    .sig_ref(sr3), .sig_dut(sd3));

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] step256(input logic [255:0] c);
    return {c[254:0], c[255] ^ c[254] ^ c[252] ^ c[251]};
  endfunction
  function automatic logic [7:0] step8(input logic [7:0] c);
    return {c[6:0], c[7] ^ c[6] ^ c[4] ^ c[3]};
  endfunction
  function automatic logic [31:0] mstep(input logic [31:0] s, input logic [31:0] f);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ f;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // walks one full run from RUN cycle 0, checking stimulus and busy each cycle
  task automatic run_vectors(input int pass_no);
    logic [255:0] lf;
    logic [7:0] lf2;
    lf = 256'd1;
    lf2 = 8'hF0;
    for (int c = 0; c < 21; c++) begin
      chk($sformatf("stim0_r%0d_v%0d", pass_no, c), stim0, (c == 0) ? 256'd0 : lf);
      chk($sformatf("sv0_r%0d_v%0d", pass_no, c), {sv0, busy0}, 2'b11);
      if (c < 3) chk($sformatf("stim2_r%0d_v%0d", pass_no, c), stim2, (c == 0) ? 8'd0 : lf2);
      if (c >= 1) begin
        lf = step256(lf);
        lf2 = step8(lf2);
      end
      @(negedge clk);
    end
  endtask

  logic [31:0] mr, md;
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_outs0", {busy0, done0, pass0, cnt0, ffi0, ffv0, sv0}, '0);
    chk("rst_stim0", stim0, '0);
    chk("rst_outs1", {busy1, done1, pass1, cnt1, ffi1, ffv1}, '0);
    chk("rst_sig3", {sr3, sd3}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs0", {busy0, done0, sv0}, '0);
    pulse_start();
    chk("stim0_v1_literal_pre", stim0, 256'd0);
    run_vectors(1);
    chk("done0", {done0, busy0, pass0}, 3'b101);
    chk("cnt0", {cnt0, ffv0}, '0);
    chk("stim0_held", stim0, 256'd1 << 19);
    chk("u1_drain", {busy1, done1, sv1}, 3'b100);
    chk("done2", {done2, pass2}, 2'b10);
    chk("cnt2_sat", cnt2, 2'd3);
    chk("ffi2", {ffv2, ffi2}, 3'b100);
    mr = '0;
    for (int i = 0; i < 21; i++) mr = mstep(mr, 32'd1);
`ifdef IDT_MISR_EN
    chk("sig_ref3_run1", sr3, mr);
    chk("sig_dut3_run1", sd3, mr);
`else
    chk("sig_off_run1", {sr3, sd3}, '0);
`endif
    @(negedge clk);
    chk("done1", {done1, busy1, pass1}, 3'b100);
    chk("cnt1", cnt1, 5'd1);
    chk("ffi1", {ffv1, ffi1}, 6'b1_00101);
    chk("done0_held", {done0, pass0}, 2'b11);
    pulse_start();
    chk("restart_clear1", {done1, cnt1, ffv1}, '0);
    repeat (10) @(negedge clk);
    chk("mid_cnt1", {busy1, cnt1, ffv1}, 7'b1_00001_1);
    rst = 1'b1;
    #1;
    chk("abort_outs1", {busy1, done1, pass1, cnt1, ffi1, ffv1, sv1}, '0);
    chk("abort_outs0", {busy0, done0, sv0}, '0);
    chk("abort_stim0", stim0, '0);
    @(negedge clk);
    rst = 1'b0;
    flip = 1'b1;
    @(negedge clk);
    pulse_start();
    run_vectors(2);
    chk("done0_r2", {done0, pass0, cnt0}, 7'b11_00000);
    md = mstep(32'd0, 32'h4000_0001);
    for (int i = 1; i < 21; i++) md = mstep(md, 32'd1);
`ifdef IDT_MISR_EN
    chk("sig_ref3_run2", sr3, mr);
    chk("sig_dut3_run2", sd3, md);
    chk("sig_differ", sd3 != sr3, 1'b1);
`else
    chk("sig_off_run2", {sr3, sd3, md == mr}, '0);
`endif
    chk("cnt3_flip", {cnt3, ffv3, ffi3}, {5'd1, 1'b1, 5'd0});
    @(negedge clk);
    chk("done1_r2", {done1, pass1, cnt1}, 7'b10_00001);
    chk("ffi1_r2", {ffv1, ffi1}, 6'b1_00101);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
